onehot_scan_decoder: RTL
========================

# onehot_scan_decoder

Parametrised, registered binary-to-one-hot decoder, successor to the fixed 3-to-8 combinational decoder. It supports a direct-decode mode and a self-running scan mode that walks the active output across all 2^N lines with a programmable dwell time. It sits between control logic and multiplexed loads such as display digit strobes, bank selects and row drivers, all on one clock domain.

## Interface
Parameters:
- N, 3, select width; output count OUTS = 2^N (derived, not overridable)
- DWELL, 4, cycles each output stays active in scan mode; legal range 1..65535

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  block enable; low forces outputs inactive
- mode  input  1  0 = direct decode, 1 = auto-scan
- sel  input  N  select index (direct mode), or start index on load (scan mode)
- load  input  1  scan mode only: restart scan at sel
- out  output  OUTS  registered one-hot output
- idx  output  N  index currently driven on out
- wrap  output  1  one-cycle pulse when scan wraps from OUTS-1 to 0

Reset and clocking are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

## Operation
States:
- IDLE: entered when en=0.
- DIRECT: entered when en=1 and mode=0.
- SCAN: entered when en=1 and mode=1.
- State transitions are evaluated every clock from en and mode.

Register behaviour by state:
- IDLE: out inactive (all 0); idx holds its last value; dwell counter cleared; wrap=0.
- DIRECT: idx <= sel; out <= one-hot(sel); dwell counter held at 0; wrap=0.
- SCAN, dwell counter: counts 0..DWELL-1.
- SCAN, advance: at count DWELL-1 the counter returns to 0 and idx increments modulo OUTS; out follows idx.
- SCAN, wrap: the increment from OUTS-1 to 0 asserts wrap for exactly that cycle.
- SCAN, load=1: idx <= sel, counter <= 0, no wrap. load has priority over the dwell advance in the same cycle.
- load is ignored outside SCAN.

Entry and boundary rules:
- Entering SCAN from DIRECT or IDLE: idx keeps its current value, counter starts at 0, out = one-hot(idx) on the first SCAN cycle.
- DWELL=1: idx advances every cycle; wrap fires every OUTS cycles.
- Mode change mid-dwell: the counter is discarded. Returning to SCAN always starts a fresh dwell period.
- Arithmetic: the counter width is ceil(log2(DWELL)), minimum 1 bit. The idx increment is N-bit and wraps naturally.
- Asynchronous reset during any state: all registers clear immediately, with no dependence on clk.

## Timing
- Reset values: out=0, idx=0, wrap=0, dwell counter=0, state IDLE.
- Direct latency: 1 cycle from sel/en/mode sampling to out/idx.
- Scan: each idx value is held for exactly DWELL cycles; one full sweep takes OUTS*DWELL cycles.
- wrap is aligned with the cycle on which idx first reads 0 after the wrap.
- load latency: 1 cycle; the new idx is held for a full DWELL.
- en falling: out is all 0 on the next edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: DEC_ACTIVE_LOW_EN.
- Defined: out is driven inverted, i.e. one-zero with all other lines high. The IDLE and reset values of out become all 1s. idx and wrap are unaffected.
- Undefined: active-high one-hot as described above.
- The inversion is applied at the output register, so the 1-cycle latency is unchanged.

## Test plan
All scenarios use N=3, DWELL=4 unless stated otherwise.

- Reset: assert rst_n=0 mid-scan, between clock edges -> out=8'h00, idx=0, wrap=0 immediately, with no clock edge needed.
- Direct sweep: en=1, mode=0, sel stepping 0..7 each cycle -> out = 8'h01, 8'h02, ... 8'h80, each one cycle after the matching sel.
- Scan: en=1, mode=1 from idx=0 -> idx holds each value for 4 cycles; wrap pulses for 1 cycle when idx goes 7->0, i.e. 32 cycles after entry.
- Load: load=1 with sel=5 at dwell count 3, coinciding with an advance -> next idx=5 (not 1), held for 4 full cycles; wrap=0.
- Disable and boundary: en=0 during scan -> out=8'h00 on the next cycle, idx held; re-enable -> resumes from the held idx with a fresh 4-cycle dwell. Also check DWELL=1: idx advances every cycle and wrap fires every 8 cycles.
- Macro build with DEC_ACTIVE_LOW_EN defined, direct mode, sel=2 -> out=8'hFB; reset value of out = 8'hFF.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with direct-decode and self-running scan modes.
// Build option: define DEC_ACTIVE_LOW_EN to drive out as one-zero (idle/reset value all 1s).
module onehot_scan_decoder #(
    parameter int N     = 3,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int OUTS = 2 ** N;
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUTS-1:0] OUT_IDLE = '1;
`else
    localparam logic [OUTS-1:0] OUT_IDLE = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [N-1:0]      idx_nxt;
    logic              wrap_nxt;
    logic [OUTS-1:0]   onehot;
    logic [OUTS-1:0]   out_nxt;

    // Register updates are chosen by the state being entered on this edge,
    // so the outputs of every cycle are consistent with that cycle's state.
    always_comb begin
        state_nxt = IDLE;
        idx_nxt   = idx;
        cnt_nxt   = '0;
        wrap_nxt  = 1'b0;
        onehot    = '0;

        if (en) begin
            state_nxt = mode ? SCAN : DIRECT;
        end

        case (state_nxt)
            DIRECT: idx_nxt = sel;
            SCAN: begin
                // On SCAN entry idx is kept and a fresh dwell starts at 0.
                if (state == SCAN) begin
                    if (load) begin
                        idx_nxt = sel;
                    end else if (cnt == CNT_LAST) begin
                        idx_nxt  = idx + 1'b1;
                        wrap_nxt = (idx == {N{1'b1}});
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (state_nxt != IDLE) begin
            onehot[idx_nxt] = 1'b1;
        end

`ifdef DEC_ACTIVE_LOW_EN
        out_nxt = ~onehot;
`else
        out_nxt = onehot;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            wrap  <= 1'b0;
            out   <= OUT_IDLE;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            wrap  <= wrap_nxt;
            out   <= out_nxt;
        end
    end

endmodule
